// File: rtl/nand_phy_async_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------------+
// | nand_phy_async_seq: async (SDR) NAND bus-cycle sequencer, one beat per command.  |
// | Option NAND_SEQ_RB_WAIT_EN adds an R/B# wait after the beat. Rev 1.0             |
// +--------------------------------------------------------------------------------+
module nand_phy_async_seq #(
  parameter int DQ_WIDTH = 8,
  parameter int NUM_CE   = 8,
  parameter int CNT_W    = 4,
  localparam int CE_W    = (NUM_CE > 1) ? $clog2(NUM_CE) : 1
) (
  input  logic                clk0_i,
  input  logic                rst0_i,
`ifdef NAND_SEQ_RB_WAIT_EN
  input  logic                rbn_i,
  input  logic                cmd_wait_rb_i,
`endif
  input  logic [CNT_W-1:0]    cfg_twp_i,
  input  logic [CNT_W-1:0]    cfg_twh_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_type_i,
  input  logic [CE_W-1:0]     cmd_ce_sel_i,
  input  logic [DQ_WIDTH-1:0] cmd_data_i,
  input  logic                cmd_last_i,
  output logic                rsp_valid_o,
  output logic [DQ_WIDTH-1:0] rsp_data_o,
  output logic                busy_o,
  output logic                ctrl_cle_o,
  output logic                ctrl_ale_o,
  output logic                ctrl_wen_o,
  output logic                ctrl_wen_sel_o,
  output logic                ctrl_wrn_o,
  output logic [NUM_CE-1:0]   ctrl_cen_o,
  output logic                dq_oe_n_o,
  output logic [DQ_WIDTH-1:0] wr_data_rise_o,
  output logic [DQ_WIDTH-1:0] wr_data_fall_o,
  input  logic [DQ_WIDTH-1:0] rd_data_rise_i
);

  localparam logic [1:0] c_T_CMD  = 2'b00;
  localparam logic [1:0] c_T_ADDR = 2'b01;
  localparam logic [1:0] c_T_DOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_TWB, S_WAIT_RB
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q, twp_q, twh_q;
  logic [1:0]          type_q;
  logic                last_q, ce_ok_q;
  logic                cle_q, ale_q, wen_q, wrn_q, oen_q, rsp_valid_q;
  logic [NUM_CE-1:0]   cen_q;
  logic [DQ_WIDTH-1:0] wr_data_q, rsp_data_q;
  logic [NUM_CE-1:0]   w_cen_d;
  logic                w_ce_ok;

  // Out-of-range selects decode to no active CE at all.
  always_comb begin
    w_cen_d = '1;
    for (int i = 0; i < NUM_CE; i++) begin
      if (cmd_ce_sel_i == CE_W'(i)) w_cen_d[i] = 1'b0;
    end
  end
  assign w_ce_ok = ({1'b0, cmd_ce_sel_i} < (CE_W+1)'(NUM_CE));

`ifdef NAND_SEQ_RB_WAIT_EN
  logic rb_meta_q, rb_sync_q, rb_seen_q, wait_rb_q;
  always_ff @(posedge clk0_i) begin
    if (rst0_i) begin
      rb_meta_q <= 1'b0;
      rb_sync_q <= 1'b0;
    end else begin
      rb_meta_q <= rbn_i;
      rb_sync_q <= rb_meta_q;
    end
  end
`endif

  always_ff @(posedge clk0_i) begin
    if (rst0_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      twp_q       <= '0;
      twh_q       <= '0;
      type_q      <= c_T_CMD;
      last_q      <= 1'b0;
      ce_ok_q     <= 1'b0;
      cle_q       <= 1'b0;
      ale_q       <= 1'b0;
      wen_q       <= 1'b1;
      wrn_q       <= 1'b1;
      oen_q       <= 1'b1;
      cen_q       <= '1;
      wr_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef NAND_SEQ_RB_WAIT_EN
      rb_seen_q   <= 1'b0;
      wait_rb_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            state_q <= S_SETUP;
            type_q  <= cmd_type_i;
            last_q  <= cmd_last_i;
            ce_ok_q <= w_ce_ok;
            twp_q   <= cfg_twp_i;
            twh_q   <= cfg_twh_i;
            cen_q   <= w_cen_d;
            cle_q   <= (cmd_type_i == c_T_CMD);
            ale_q   <= (cmd_type_i == c_T_ADDR);
            oen_q   <= (cmd_type_i == c_T_DOUT);
            if (cmd_type_i != c_T_DOUT) wr_data_q <= cmd_data_i;
`ifdef NAND_SEQ_RB_WAIT_EN
            wait_rb_q <= cmd_wait_rb_i;
`endif
          end
        end
        S_SETUP: begin
          state_q <= S_PULSE;
          cnt_q   <= twp_q;
          if (type_q == c_T_DOUT) wrn_q <= 1'b0;
          else                    wen_q <= 1'b0;
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            state_q <= S_HOLD;
            cnt_q   <= twh_q;
            wen_q   <= 1'b1;
            wrn_q   <= 1'b1;
            if (type_q == c_T_DOUT) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= ce_ok_q ? rd_data_rise_i : '0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            cle_q <= 1'b0;
            ale_q <= 1'b0;
            oen_q <= 1'b1;
            if (last_q) cen_q <= '1;
`ifdef NAND_SEQ_RB_WAIT_EN
            state_q <= wait_rb_q ? S_TWB : S_IDLE;
`else
            state_q <= S_IDLE;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`ifdef NAND_SEQ_RB_WAIT_EN
        S_TWB: begin
          state_q   <= S_WAIT_RB;
          rb_seen_q <= 1'b0;
        end
        S_WAIT_RB: begin
          // Ready only after two consecutive synchronised high samples.
          rb_seen_q <= rb_sync_q;
          if (rb_seen_q && rb_sync_q) state_q <= S_IDLE;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o    = (state_q == S_IDLE) && !rst0_i;
  assign busy_o         = (state_q != S_IDLE);
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign ctrl_cle_o     = cle_q;
  assign ctrl_ale_o     = ale_q;
  assign ctrl_wen_o     = wen_q;
  assign ctrl_wen_sel_o = 1'b1;
  assign ctrl_wrn_o     = wrn_q;
  assign ctrl_cen_o     = cen_q;
  assign dq_oe_n_o      = oen_q;
  assign wr_data_rise_o = wr_data_q;
  assign wr_data_fall_o = wr_data_q;

endmodule
`default_nettype wire
